intr_arbiter: RTL and testbench
===============================

# intr_arbiter

Shares one Unibus bus-request level among up to NDEV local interrupt sources, for example the line clock at vector 100 and the console DL11. Each source raises an `intreq` level and presents an 8-bit `intvec`. The block latches requests, asserts BR, and takes the bus grant or passes it downstream. It then runs the SACK/BBSY/INTR vector transfer and tells the winning source it was serviced. It sits between the device modules and the top-level Unibus signal merge.

## Interface
- NDEV, 4: number of sources, 1..8. Index 0 has the highest priority.
- SSYNTMO, 2000: SSYN timeout, in CLOCK cycles.
- CLOCK  in  1  system clock (100 MHz).
- RESET  in  1  asynchronous, active-low reset.
- intreqs  in  NDEV  per-source interrupt request level.
- intvecs  in  8*NDEV  per-source vector; source i uses bits [8i+7:8i].
- intgnts  out  NDEV  one-cycle pulse naming the source whose vector was accepted.
- init_in_h  in  1  Unibus INIT.
- bg_in_h  in  1  bus grant from upstream.
- bg_out_h  out  1  bus grant passed downstream.
- br_out_h  out  1  bus request.
- sack_out_h  out  1  selection acknowledge.
- bbsy_in_h  in  1  bus busy, as seen on the bus.
- bbsy_out_h  out  1  bus busy, driven by this block.
- intr_out_h  out  1  INTR.
- ssyn_in_h  in  1  SSYN from the processor.
- d_out_h  out  16  vector data; carries {8'b0, vec} in the INTR state and 0 otherwise.
- tmo_out  out  1  one-cycle pulse on an SSYN timeout; present only when the macro is defined.

## Operation
- Pending latch per source:
  - Sets on a 0→1 transition of `intreqs[i]`, using a registered copy of the previous value.
  - Clears on that source's `intgnts` pulse.
  - If set and clear occur in the same cycle, set wins.
  - `init_in_h` clears all pending bits and forces IDLE. It is synchronous and overrides everything except RESET.
- States: IDLE, REQ, SACK, WTBUS, INTR, DONE, PASS.
- IDLE
  - Any pending bit set and `bg_in_h` low → REQ.
  - `bg_in_h` high → PASS, whatever the pending state.
- REQ
  - `br_out_h` = 1.
  - When `bg_in_h` is seen high: capture the lowest-index pending source (index and vector) and go to SACK.
  - If no bit is pending at that moment (not possible normally, guarded anyway): go to PASS.
- SACK
  - `sack_out_h` = 1, `br_out_h` = 0.
  - Wait until `bg_in_h`, `bbsy_in_h` and `ssyn_in_h` are all low, then go to INTR.
- INTR
  - `bbsy_out_h` = 1, `intr_out_h` = 1, `d_out_h` = captured vector.
  - `sack_out_h` drops on entry.
  - On `ssyn_in_h` high → DONE, pulse `intgnts[captured]`.
- DONE
  - All outputs 0.
  - Wait until `ssyn_in_h` is low, then go to IDLE.
- PASS
  - `bg_out_h` = `bg_in_h` (combinational).
  - Return to IDLE when `bg_in_h` falls.
- `bg_out_h` is 0 in every state except PASS. A grant is never both taken and passed.
- Winner selection is frozen at capture. Higher-priority requests arriving later wait for the next cycle through the state machine.

## Timing
- At reset and after INIT: all outputs 0, state IDLE, pending bits 0.
- Request latency: `intreqs` rise at cycle n → pending set at n+1 → `br_out_h` high at n+2.
- Grant capture: `bg_in_h` high at cycle m in REQ → `sack_out_h` high and `br_out_h` low at m+1.
- INTR entry: one cycle after the SACK-state conditions are met.
- `intgnts` pulse: in the cycle after `ssyn_in_h` is first seen high; `intr_out_h` falls in that same cycle.
- All outputs are registered except `bg_out_h`.
- RESET in mid-transfer drops every bus line asynchronously.

## Configuration
- SSYNTMO_EN defined:
  - A 16-bit counter runs in INTR and SACK.
  - When it reaches SSYNTMO: release all bus lines, pulse `tmo_out`, leave the captured pending bit set, return to IDLE.
  - The source then re-requests.
- SSYNTMO_EN undefined:
  - INTR and SACK wait indefinitely.
  - `tmo_out` is tied to 0.

## Structure
- Shared package `unibus_pkg` holds:
  - the state enum;
  - the source count limit, 8;
  - the vector width, 8;
  - the Unibus vector constants (line clock = 8'o100).
- One sub-module, `prio_enc`: NDEV-bit lowest-index-first priority encoder, outputs index and valid.

## Test plan
- Source 1 requests with vector 8'o100; bench gives BG after 3 cycles and SSYN 5 cycles after INTR → `d_out_h` = 16'o000100 during INTR; `intgnts` = 4'b0010 for exactly one cycle.
- Sources 0 and 2 request in the same cycle → first transfer carries source 0's vector, then BR reasserts and source 2's vector follows.
- `bg_in_h` high with no requests pending → `bg_out_h` tracks `bg_in_h`; SACK never asserts.
- Source held high through service and never dropped → no second request until it falls and rises again.
- INIT asserted while in INTR → all bus outputs 0 next cycle, pending bits cleared, state IDLE.
- SSYNTMO_EN defined, SSYN withheld → `tmo_out` pulses after 2000 cycles; BR reasserts with the same vector.

Source files
------------

// File: rtl/unibus_pkg.sv
// Shared Unibus interrupt-arbiter types and constants.
// State encoding, source/vector sizing and standard PDP-11 device vectors.
package unibus_pkg;
  localparam int MAX_SRC = 8;
  localparam int VEC_W   = 8;
  localparam int IDX_W   = $clog2(MAX_SRC);

  localparam logic [VEC_W-1:0] VEC_LINE_CLK = 8'o100;
  localparam logic [VEC_W-1:0] VEC_DL11_RX  = 8'o060;
  localparam logic [VEC_W-1:0] VEC_DL11_TX  = 8'o064;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SACK,
    ST_WTBUS,
    ST_INTR,
    ST_DONE,
    ST_PASS
  } arb_state_t;
endpackage

// File: rtl/prio_enc.sv
// Lowest-index-first priority encoder; combinational, zero latency.
// vld is low and idx is 0 when no request bit is set.
module prio_enc
  import unibus_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_arbiter.sv
// Shares one Unibus BR level among NDEV sources and runs the SACK/BBSY/INTR vector transfer.
// Outputs registered except bg_out_h; SSYNTMO_EN adds an SSYN timeout (tmo_out otherwise tied 0).
module intr_arbiter
  import unibus_pkg::*;
#(
  parameter int NDEV    = 4,
  parameter int SSYNTMO = 2000
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic [NDEV-1:0]       intreqs,
  input  logic [VEC_W*NDEV-1:0] intvecs,
  output logic [NDEV-1:0]       intgnts,
  input  logic                  init_in_h,
  input  logic                  bg_in_h,
  output logic                  bg_out_h,
  output logic                  br_out_h,
  output logic                  sack_out_h,
  input  logic                  bbsy_in_h,
  output logic                  bbsy_out_h,
  output logic                  intr_out_h,
  input  logic                  ssyn_in_h,
  output logic [15:0]           d_out_h,
  output logic                  tmo_out
);

  arb_state_t       state, state_nxt;
  logic [NDEV-1:0]  req_q;
  logic [NDEV-1:0]  pend, pend_nxt;
  logic [NDEV-1:0]  gnt_nxt;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_vld;
  logic [IDX_W-1:0] cap_idx, cap_idx_nxt;
  logic [VEC_W-1:0] cap_vec, cap_vec_nxt;
  logic [VEC_W-1:0] sel_vec;
  logic             tmo_hit;

  prio_enc #(.N(NDEV)) u_prio_enc (
    .req (pend),
    .idx (enc_idx),
    .vld (enc_vld)
  );

  always_comb begin
    sel_vec = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (enc_idx == IDX_W'(i)) sel_vec = intvecs[VEC_W*i +: VEC_W];
    end
  end

  // A new rising edge beats a simultaneous grant clear.
  assign pend_nxt = init_in_h ? '0 : ((intreqs & ~req_q) | (pend & ~intgnts));

`ifdef SSYNTMO_EN
  logic [15:0] tmo_cnt;
  logic        tmo_q;

  assign tmo_hit = ((state == ST_SACK) || (state == ST_INTR)) && (tmo_cnt == 16'(SSYNTMO - 1));

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      if (init_in_h || tmo_hit || !((state == ST_SACK) || (state == ST_INTR)))
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 16'd1;
      tmo_q <= tmo_hit && !init_in_h;
    end
  end

  assign tmo_out = tmo_q;
`else
  assign tmo_hit = 1'b0;
  assign tmo_out = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    cap_idx_nxt = cap_idx;
    cap_vec_nxt = cap_vec;
    gnt_nxt     = '0;
    case (state)
      ST_IDLE: begin
        if (bg_in_h)    state_nxt = ST_PASS;
        else if (|pend) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (bg_in_h) begin
          if (enc_vld) begin
            state_nxt   = ST_SACK;
            cap_idx_nxt = enc_idx;
            cap_vec_nxt = sel_vec;
          end else begin
            state_nxt = ST_PASS;
          end
        end
      end
      ST_SACK: begin
        if (tmo_hit)                                 state_nxt = ST_IDLE;
        else if (!bg_in_h && !bbsy_in_h && !ssyn_in_h) state_nxt = ST_INTR;
      end
      ST_INTR: begin
        if (tmo_hit) begin
          state_nxt = ST_IDLE;
        end else if (ssyn_in_h) begin
          state_nxt = ST_DONE;
          for (int i = 0; i < NDEV; i++) begin
            if (cap_idx == IDX_W'(i)) gnt_nxt[i] = 1'b1;
          end
        end
      end
      ST_DONE: if (!ssyn_in_h) state_nxt = ST_IDLE;
      ST_PASS: if (!bg_in_h)   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (init_in_h) begin
      state_nxt = ST_IDLE;
      gnt_nxt   = '0;
    end
  end

  // Bus outputs decode the upcoming state so they change on the same edge as the state.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state      <= ST_IDLE;
      req_q      <= '0;
      pend       <= '0;
      cap_idx    <= '0;
      cap_vec    <= '0;
      intgnts    <= '0;
      br_out_h   <= 1'b0;
      sack_out_h <= 1'b0;
      bbsy_out_h <= 1'b0;
      intr_out_h <= 1'b0;
      d_out_h    <= '0;
    end else begin
      state      <= state_nxt;
      req_q      <= intreqs;
      pend       <= pend_nxt;
      cap_idx    <= cap_idx_nxt;
      cap_vec    <= cap_vec_nxt;
      intgnts    <= gnt_nxt;
      br_out_h   <= (state_nxt == ST_REQ);
      sack_out_h <= (state_nxt == ST_SACK);
      bbsy_out_h <= (state_nxt == ST_INTR);
      intr_out_h <= (state_nxt == ST_INTR);
      d_out_h    <= (state_nxt == ST_INTR) ? {8'h00, cap_vec_nxt} : 16'h0000;
    end
  end

  assign bg_out_h = (state == ST_PASS) && bg_in_h;

endmodule

// File: tb/tb_intr_arbiter.sv
// Self-checking bench for intr_arbiter: bench acts as processor/bus and compares against a
// pending-set model where the winner of each transfer is the lowest-index pending source.
module tb_intr_arbiter;
  import unibus_pkg::*;

  localparam int NDEV    = 4;
  localparam int SSYNTMO = 2000;

  logic                  CLOCK = 1'b0;
  logic                  RESET = 1'b0;
  logic [NDEV-1:0]       intreqs = '0;
  logic [8*NDEV-1:0]     intvecs = '0;
  logic [NDEV-1:0]       intgnts;
  logic                  init_in_h = 1'b0;
  logic                  bg_in_h = 1'b0;
  logic                  bg_out_h;
  logic                  br_out_h;
  logic                  sack_out_h;
  logic                  bbsy_in_h = 1'b0;
  logic                  bbsy_out_h;
  logic                  intr_out_h;
  logic                  ssyn_in_h = 1'b0;
  logic [15:0]           d_out_h;
  logic                  tmo_out;

  int checks = 0;
  int errors = 0;
  bit model_pend[NDEV];

  intr_arbiter #(.NDEV(NDEV), .SSYNTMO(SSYNTMO)) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .intreqs    (intreqs),
    .intvecs    (intvecs),
    .intgnts    (intgnts),
    .init_in_h  (init_in_h),
    .bg_in_h    (bg_in_h),
    .bg_out_h   (bg_out_h),
    .br_out_h   (br_out_h),
    .sack_out_h (sack_out_h),
    .bbsy_in_h  (bbsy_in_h),
    .bbsy_out_h (bbsy_out_h),
    .intr_out_h (intr_out_h),
    .ssyn_in_h  (ssyn_in_h),
    .d_out_h    (d_out_h),
    .tmo_out    (tmo_out)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  function automatic int model_winner();
    for (int i = 0; i < NDEV; i++) if (model_pend[i]) return i;
    return -1;
  endfunction

  // Only a low-to-high change of the request line creates a pending request.
  task automatic raise(input int i, input logic [7:0] v);
    intvecs[8*i +: 8] = v;
    if (!intreqs[i]) model_pend[i] = 1'b1;
    intreqs[i] = 1'b1;
  endtask

  task automatic serve(input int bg_dly, input int ssyn_dly, input string tag);
    int w;
    logic [7:0] v;
    bit seen;
    w = model_winner();
    checks++;
    if (w < 0) begin
      errors++;
      $display("FAIL %s model: no pending source to serve", tag);
      return;
    end
    v = intvecs[8*w +: 8];
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (br_out_h) seen = 1'b1;
      else step();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s br: got 0 for 40 cycles, required 1", tag);
      return;
    end
    repeat (bg_dly) step();
    bg_in_h = 1'b1;
    step();
    checks++;
    if ({sack_out_h, br_out_h, bg_out_h} !== 3'b100) begin
      errors++;
      $display("FAIL %s grant_take: sack/br/bg_out=%b required 100", tag, {sack_out_h, br_out_h, bg_out_h});
    end
    bg_in_h = 1'b0;
    step();
    checks++;
    if ({intr_out_h, bbsy_out_h, sack_out_h} !== 3'b110 || d_out_h !== {8'h00, v}) begin
      errors++;
      $display("FAIL %s intr: intr/bbsy/sack=%b d=%o required 110 d=%o", tag,
               {intr_out_h, bbsy_out_h, sack_out_h}, d_out_h, {8'h00, v});
    end
    repeat (ssyn_dly) step();
    ssyn_in_h = 1'b1;
    step();
    checks++;
    if (intgnts !== NDEV'(1 << w) || intr_out_h !== 1'b0 || d_out_h !== 16'h0) begin
      errors++;
      $display("FAIL %s gnt: intgnts=%b intr=%b d=%o required intgnts=%b intr=0 d=0", tag,
               intgnts, intr_out_h, d_out_h, NDEV'(1 << w));
    end
    step();
    checks++;
    if (intgnts !== '0) begin
      errors++;
      $display("FAIL %s gnt_width: intgnts=%b required 0000", tag, intgnts);
    end
    ssyn_in_h = 1'b0;
    step();
    model_pend[w] = 1'b0;
  endtask

  task automatic drop_all();
    intreqs = '0;
    step();
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({br_out_h, sack_out_h, bbsy_out_h, intr_out_h, bg_out_h, tmo_out, intgnts, d_out_h} !== '0) begin
      errors++;
      $display("FAIL reset: br/sack/bbsy/intr/bg/tmo=%b gnts=%b d=%o required all 0",
               {br_out_h, sack_out_h, bbsy_out_h, intr_out_h, bg_out_h, tmo_out}, intgnts, d_out_h);
    end
    RESET = 1'b1;
    step();
  endtask

  task automatic test_single();
    raise(1, VEC_LINE_CLK);
    step();
    checks++;
    if (br_out_h !== 1'b0) begin
      errors++;
      $display("FAIL req_latency_n1: br=%b required 0", br_out_h);
    end
    step();
    checks++;
    if (br_out_h !== 1'b1) begin
      errors++;
      $display("FAIL req_latency_n2: br=%b required 1", br_out_h);
    end
    serve(3, 5, "single");
  endtask

  task automatic test_held();
    int br_seen = 0;
    repeat (15) begin
      step();
      if (br_out_h) br_seen++;
    end
    checks++;
    if (br_seen != 0) begin
      errors++;
      $display("FAIL held_no_rereq: br high for %0d cycles required 0", br_seen);
    end
    intreqs[1] = 1'b0;
    step();
    raise(1, VEC_DL11_TX);
    serve(1, 2, "rerequest");
  endtask

  task automatic test_two();
    drop_all();
    raise(0, VEC_DL11_RX);
    raise(2, VEC_LINE_CLK);
    serve(2, 1, "pair_first");
    serve(0, 3, "pair_second");
  endtask

  task automatic test_pass();
    int bad = 0;
    drop_all();
    bg_in_h = 1'b1;
    step();
    repeat (5) begin
      if (bg_out_h !== 1'b1 || sack_out_h !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL pass_track: %0d cycles bg_out!=1 or sack!=0, required 0", bad);
    end
    bg_in_h = 1'b0;
    #1;
    checks++;
    if (bg_out_h !== 1'b0) begin
      errors++;
      $display("FAIL pass_release: bg_out=%b required 0", bg_out_h);
    end
    step();
  endtask

  task automatic test_init();
    int br_seen = 0;
    drop_all();
    raise(3, 8'o344);
    repeat (3) step();
    bg_in_h = 1'b1;
    step();
    bg_in_h = 1'b0;
    step();
    checks++;
    if (intr_out_h !== 1'b1) begin
      errors++;
      $display("FAIL init_setup: intr=%b required 1", intr_out_h);
    end
    init_in_h = 1'b1;
    step();
    checks++;
    if ({br_out_h, sack_out_h, bbsy_out_h, intr_out_h, bg_out_h, intgnts, d_out_h} !== '0) begin
      errors++;
      $display("FAIL init_clear: br/sack/bbsy/intr/bg=%b gnts=%b d=%o required all 0",
               {br_out_h, sack_out_h, bbsy_out_h, intr_out_h, bg_out_h}, intgnts, d_out_h);
    end
    init_in_h = 1'b0;
    model_pend[3] = 1'b0;
    repeat (10) begin
      step();
      if (br_out_h) br_seen++;
    end
    checks++;
    if (br_seen != 0) begin
      errors++;
      $display("FAIL init_pending: br high for %0d cycles required 0", br_seen);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int mask;
      drop_all();
      mask = $urandom_range(1, (1 << NDEV) - 1);
      for (int i = 0; i < NDEV; i++)
        if (mask[i]) raise(i, 8'($urandom));
      for (int k = 0; k < NDEV && model_winner() >= 0; k++)
        serve($urandom_range(0, 4), $urandom_range(0, 6), "random");
    end
  endtask

`ifdef SSYNTMO_EN
  task automatic test_timeout();
    int k;
    drop_all();
    raise(2, 8'o070);
    repeat (3) step();
    bg_in_h = 1'b1;
    step();
    bg_in_h = 1'b0;
    k = 0;
    while (k < 3000 && !tmo_out) begin
      step();
      k++;
    end
    checks++;
    if (k != SSYNTMO) begin
      errors++;
      $display("FAIL tmo_time: tmo seen after %0d cycles required %0d", k, SSYNTMO);
    end
    serve(0, 2, "after_tmo");
  endtask
`else
  task automatic test_timeout();
    int seen = 0;
    drop_all();
    raise(2, 8'o070);
    repeat (3) step();
    bg_in_h = 1'b1;
    step();
    bg_in_h = 1'b0;
    repeat (50) begin
      step();
      if (tmo_out) seen++;
    end
    checks++;
    if (seen != 0 || intr_out_h !== 1'b1) begin
      errors++;
      $display("FAIL no_tmo: tmo pulses=%0d intr=%b required 0 and 1", seen, intr_out_h);
    end
    ssyn_in_h = 1'b1;
    step();
    step();
    ssyn_in_h = 1'b0;
    step();
    model_pend[2] = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NDEV; i++) model_pend[i] = 1'b0;
    test_reset();
    test_single();
    test_held();
    test_two();
    test_pass();
    test_init();
    test_random();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
